// File: rtl/compressor_tree_pipe_if.sv
// Operand-vector / carry-save-result handshake bundle for compressor_tree_pipe.
// slave: the reduction tree; master: the upstream/downstream side driving it.
interface compressor_tree_pipe_if #(
  parameter int NUM_IN = 6,
  parameter int WIDTH  = 16
);
  localparam int OUT_WIDTH = WIDTH + $clog2(NUM_IN);

  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_WIDTH-1:0]    out_sum;
  logic [OUT_WIDTH-1:0]    out_carry;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );
endinterface

// File: rtl/compressor_tree_pipe.sv
// Pipelined 3:2 carry-save tree: NUM_IN operands -> sum/carry pair, register after every PIPE_EVERY levels.
// Latency ceil(LEVELS/PIPE_EVERY) cycles (+1 with COMPRESSOR_FINAL_ADD_EN); global stall, in_ready = !out_valid || out_ready.
module compressor_tree_pipe #(
  parameter int NUM_IN     = 6,
  parameter int WIDTH      = 16,
  parameter int PIPE_EVERY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  compressor_tree_pipe_if.slave bus
);

  localparam int OUT_WIDTH = WIDTH + $clog2(NUM_IN);

  function automatic int rows_after(input int lvls);
    int n;
    n = NUM_IN;
    for (int i = 0; i < lvls; i++) n = 2 * (n / 3) + (n % 3);
    return n;
  endfunction

  function automatic int count_levels(input int n0);
    int n;
    int c;
    n = n0;
    c = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      c++;
    end
    return c;
  endfunction

  localparam int LEVELS = count_levels(NUM_IN);

  // Every stage moves together; a stalled output freezes the whole pipe.
  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = rows_after(l);
    localparam int NT = NI / 3;
    localparam int NO = 2 * NT + (NI % 3);

    logic [OUT_WIDTH-1:0] src [NI];
    logic [OUT_WIDTH-1:0] nxt [NO];
    logic [OUT_WIDTH-1:0] dst [NO];
    logic                 src_vld;
    logic                 dst_vld;

    if (l == 0) begin : g_src_in
      for (genvar r = 0; r < NUM_IN; r++) begin : g_row
        assign src[r] = {{(OUT_WIDTH-WIDTH){1'b0}}, bus.in_data[r*WIDTH +: WIDTH]};
      end
      assign src_vld = bus.in_valid;
    end else begin : g_src_prev
      assign src     = g_lvl[l-1].dst;
      assign src_vld = g_lvl[l-1].dst_vld;
    end

    // Triples from row 0 upward; carry lands one bit up, the top carry falls off.
    for (genvar t = 0; t < NT; t++) begin : g_csa
      assign nxt[2*t]   = src[3*t] ^ src[3*t+1] ^ src[3*t+2];
      assign nxt[2*t+1] = ((src[3*t]   & src[3*t+1]) |
                           (src[3*t]   & src[3*t+2]) |
                           (src[3*t+1] & src[3*t+2])) << 1;
    end

    for (genvar r = 3 * NT; r < NI; r++) begin : g_pass
      assign nxt[2*NT + r - 3*NT] = src[r];
    end

    if (((l + 1) % PIPE_EVERY == 0) || (l == LEVELS - 1)) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dst_vld <= 1'b0;
          dst     <= '{default: '0};
        end else if (adv) begin
          dst_vld <= src_vld;
          dst     <= nxt;
        end
      end
    end else begin : g_comb
      assign dst     = nxt;
      assign dst_vld = src_vld;
    end
  end

`ifdef COMPRESSOR_FINAL_ADD_EN
  logic                 fa_vld;
  logic [OUT_WIDTH-1:0] fa_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa_vld <= 1'b0;
      fa_sum <= '0;
    end else if (adv) begin
      fa_vld <= g_lvl[LEVELS-1].dst_vld;
      fa_sum <= g_lvl[LEVELS-1].dst[0] + g_lvl[LEVELS-1].dst[1];
    end
  end

  assign bus.out_valid = fa_vld;
  assign bus.out_sum   = fa_sum;
  assign bus.out_carry = '0;
`else
  assign bus.out_valid = g_lvl[LEVELS-1].dst_vld;
  assign bus.out_sum   = g_lvl[LEVELS-1].dst[0];
  assign bus.out_carry = g_lvl[LEVELS-1].dst[1];
`endif

endmodule

// File: tb/tb_compressor_tree_pipe.sv
// Bench for compressor_tree_pipe: 6-input/PIPE_EVERY=1 and 9-input/PIPE_EVERY=2 instances, queue scoreboards.
module tb_compressor_tree_pipe;
  localparam int W   = 16;
  localparam int NA  = 6;
  localparam int NB  = 9;
  localparam int OWA = 19;
  localparam int OWB = 20;
`ifdef COMPRESSOR_FINAL_ADD_EN
  localparam int LAT_A = 4;
  localparam int LAT_B = 3;
`else
  localparam int LAT_A = 3;
  localparam int LAT_B = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  compressor_tree_pipe_if #(.NUM_IN(NA), .WIDTH(W)) a_if ();
  compressor_tree_pipe_if #(.NUM_IN(NB), .WIDTH(W)) b_if ();

  compressor_tree_pipe #(.NUM_IN(NA), .WIDTH(W), .PIPE_EVERY(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  compressor_tree_pipe #(.NUM_IN(NB), .WIDTH(W), .PIPE_EVERY(2)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  logic [OWA-1:0] exp_a [$];
  logic [OWA-1:0] got_a [$];
  logic [OWB-1:0] exp_b [$];
  logic [OWB-1:0] got_b [$];

  function automatic logic [OWA-1:0] ref_a(input logic [NA*W-1:0] d);
    logic [OWA-1:0] s;
    s = '0;
    for (int k = 0; k < NA; k++) s = s + OWA'(d[k*W +: W]);
    return s;
  endfunction

  function automatic logic [OWB-1:0] ref_b(input logic [NB*W-1:0] d);
    logic [OWB-1:0] s;
    s = '0;
    for (int k = 0; k < NB; k++) s = s + OWB'(d[k*W +: W]);
    return s;
  endfunction

  // Handshakes are sampled mid-cycle; they complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_if.in_valid && a_if.in_ready)   exp_a.push_back(ref_a(a_if.in_data));
      if (a_if.out_valid && a_if.out_ready) got_a.push_back(OWA'(a_if.out_sum + a_if.out_carry));
      if (b_if.in_valid && b_if.in_ready)   exp_b.push_back(ref_b(b_if.in_data));
      if (b_if.out_valid && b_if.out_ready) got_b.push_back(OWB'(b_if.out_sum + b_if.out_carry));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    tests++; if (a_if.out_valid !== 1'b0) begin failed++; $display("FAIL reset a out_valid: got %b, expected 0", a_if.out_valid); end
    tests++; if (a_if.out_sum !== '0) begin failed++; $display("FAIL reset a out_sum: got %h, expected 0", a_if.out_sum); end
    tests++; if (a_if.out_carry !== '0) begin failed++; $display("FAIL reset a out_carry: got %h, expected 0", a_if.out_carry); end
    tests++; if (a_if.in_ready !== 1'b1) begin failed++; $display("FAIL reset a in_ready: got %b, expected 1", a_if.in_ready); end
    tests++; if (b_if.out_valid !== 1'b0) begin failed++; $display("FAIL reset b out_valid: got %b, expected 0", b_if.out_valid); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tests++; if (a_if.out_valid !== 1'b0) begin failed++; $display("FAIL post-reset a out_valid: got %b, expected 0", a_if.out_valid); end
    tests++; if (b_if.in_ready !== 1'b1) begin failed++; $display("FAIL post-reset b in_ready: got %b, expected 1", b_if.in_ready); end
  endtask

  task automatic test_all_ones();
    int lat;
    logic [OWA-1:0] r;
    logic [OWA-1:0] e;
    a_if.out_ready = 1'b1;
    a_if.in_data   = '1;
    a_if.in_valid  = 1'b1;
    tick();
    a_if.in_valid = 1'b0;
    lat = 1;
    while (!a_if.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    r = OWA'(a_if.out_sum + a_if.out_carry);
    tests++; if (lat != LAT_A) begin failed++; $display("FAIL ones latency: got %0d, expected %0d", lat, LAT_A); end
    tests++; if (r !== 19'h5FFFA) begin failed++; $display("FAIL ones sum+carry: got %h, expected 5fffa", r); end
`ifdef COMPRESSOR_FINAL_ADD_EN
    tests++; if (a_if.out_carry !== '0) begin failed++; $display("FAIL ones final-add carry: got %h, expected 0", a_if.out_carry); end
    tests++; if (a_if.out_sum !== 19'h5FFFA) begin failed++; $display("FAIL ones final-add sum: got %h, expected 5fffa", a_if.out_sum); end
`endif
    tick();
    tests++; if (got_a.size() != 1 || exp_a.size() != 1) begin failed++; $display("FAIL ones count: got %0d results, expected %0d", got_a.size(), exp_a.size()); end
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      r = got_a.pop_front();
      e = exp_a.pop_front();
      tests++; if (r !== e) begin failed++; $display("FAIL ones scoreboard: got %h, expected %h", r, e); end
    end
    got_a.delete();
    exp_a.delete();
  endtask

  task automatic test_back_to_back();
    int rdy_drops;
    int bubbles;
    logic [OWA-1:0] r;
    logic [OWA-1:0] e;
    rdy_drops = 0;
    bubbles   = 0;
    a_if.out_ready = 1'b1;
    a_if.in_valid  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a_if.in_data = {$urandom(), $urandom(), $urandom()};
      if (!a_if.in_ready) rdy_drops++;
      if (i >= LAT_A && !a_if.out_valid) bubbles++;
      tick();
    end
    a_if.in_valid = 1'b0;
    repeat (LAT_A + 1) tick();
    tests++; if (rdy_drops != 0) begin failed++; $display("FAIL b2b in_ready drops: got %0d, expected 0", rdy_drops); end
    tests++; if (bubbles != 0) begin failed++; $display("FAIL b2b output bubbles: got %0d, expected 0", bubbles); end
    tests++; if (got_a.size() != 1000) begin failed++; $display("FAIL b2b result count: got %0d, expected 1000", got_a.size()); end
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      r = got_a.pop_front();
      e = exp_a.pop_front();
      tests++; if (r !== e) begin failed++; $display("FAIL b2b scoreboard: got %h, expected %h", r, e); end
    end
    got_a.delete();
    exp_a.delete();
  endtask

  task automatic test_stall();
    int n;
    logic [OWA-1:0] s0;
    logic [OWA-1:0] c0;
    logic [OWA-1:0] r;
    logic [OWA-1:0] e;
    a_if.out_ready = 1'b0;
    for (int k = 0; k < NA; k++) a_if.in_data[k*W +: W] = 16'(k % 3 + 1);
    a_if.in_valid = 1'b1;
    tick();
    a_if.in_valid = 1'b0;
    n = 1;
    while (!a_if.out_valid && n < 20) begin
      tick();
      n++;
    end
    s0 = a_if.out_sum;
    c0 = a_if.out_carry;
    r  = OWA'(s0 + c0);
    tests++; if (r !== 19'd12) begin failed++; $display("FAIL stall value: got %0d, expected 12", r); end
    a_if.in_data  = {NA{16'h0001}};
    a_if.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (a_if.out_valid !== 1'b1) begin failed++; $display("FAIL stall out_valid cyc %0d: got %b, expected 1", i, a_if.out_valid); end
      tests++; if (a_if.in_ready !== 1'b0) begin failed++; $display("FAIL stall in_ready cyc %0d: got %b, expected 0", i, a_if.in_ready); end
      tests++; if (a_if.out_sum !== s0 || a_if.out_carry !== c0) begin failed++; $display("FAIL stall stable cyc %0d: got %h/%h, expected %h/%h", i, a_if.out_sum, a_if.out_carry, s0, c0); end
      tick();
    end
    a_if.out_ready = 1'b1;
    #1;
    tests++; if (a_if.in_ready !== 1'b1) begin failed++; $display("FAIL stall release in_ready: got %b, expected 1", a_if.in_ready); end
    tick();
    a_if.in_valid = 1'b0;
    repeat (LAT_A + 2) tick();
    tests++; if (got_a.size() != 2 || exp_a.size() != 2) begin failed++; $display("FAIL stall count: got %0d results, expected 2 (%0d accepted)", got_a.size(), exp_a.size()); end
    while (got_a.size() > 0 && exp_a.size() > 0) begin
      r = got_a.pop_front();
      e = exp_a.pop_front();
      tests++; if (r !== e) begin failed++; $display("FAIL stall scoreboard: got %h, expected %h", r, e); end
    end
    got_a.delete();
    exp_a.delete();
  endtask

  task automatic test_random_pipe2();
    int lat;
    logic [159:0] rnd;
    logic [OWB-1:0] r;
    logic [OWB-1:0] e;
    b_if.out_ready = 1'b1;
    b_if.in_data   = '1;
    b_if.in_valid  = 1'b1;
    tick();
    b_if.in_valid = 1'b0;
    lat = 1;
    while (!b_if.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    r = OWB'(b_if.out_sum + b_if.out_carry);
    tests++; if (lat != LAT_B) begin failed++; $display("FAIL pipe2 latency: got %0d, expected %0d", lat, LAT_B); end
    tests++; if (r !== 20'h8FFF7) begin failed++; $display("FAIL pipe2 ones: got %h, expected 8fff7", r); end
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      b_if.in_data   = rnd[NB*W-1:0];
      b_if.in_valid  = 1'($urandom_range(0, 1));
      b_if.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    b_if.in_valid  = 1'b0;
    b_if.out_ready = 1'b1;
    repeat (LAT_B + 2) tick();
    tests++; if (got_b.size() != exp_b.size()) begin failed++; $display("FAIL pipe2 count: got %0d results, expected %0d", got_b.size(), exp_b.size()); end
    while (got_b.size() > 0 && exp_b.size() > 0) begin
      r = got_b.pop_front();
      e = exp_b.pop_front();
      tests++; if (r !== e) begin failed++; $display("FAIL pipe2 scoreboard: got %h, expected %h", r, e); end
    end
    got_b.delete();
    exp_b.delete();
  endtask

  task automatic test_reset_inflight();
    int stale;
    a_if.out_ready = 1'b1;
    a_if.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.in_data = {$urandom() | 32'h1, $urandom(), $urandom()};
      tick();
    end
    a_if.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (a_if.out_valid !== 1'b0) begin failed++; $display("FAIL inflight reset out_valid: got %b, expected 0", a_if.out_valid); end
    tests++; if (a_if.out_sum !== '0 || a_if.out_carry !== '0) begin failed++; $display("FAIL inflight reset data: got %h/%h, expected 0/0", a_if.out_sum, a_if.out_carry); end
    tests++; if (a_if.in_ready !== 1'b1) begin failed++; $display("FAIL inflight reset in_ready: got %b, expected 1", a_if.in_ready); end
    exp_a.delete();
    got_a.delete();
    tick();
    rst_n = 1'b1;
    stale = 0;
    repeat (10) begin
      tick();
      if (a_if.out_valid) stale++;
    end
    tests++; if (stale != 0) begin failed++; $display("FAIL inflight stale out_valid cycles: got %0d, expected 0", stale); end
    tests++; if (got_a.size() != 0) begin failed++; $display("FAIL inflight stale results: got %0d, expected 0", got_a.size()); end
  endtask

  initial begin
    rst_n          = 1'b1;
    a_if.in_valid  = 1'b0;
    a_if.in_data   = '0;
    a_if.out_ready = 1'b1;
    b_if.in_valid  = 1'b0;
    b_if.in_data   = '0;
    b_if.out_ready = 1'b1;
    test_reset();
    test_all_ones();
    test_back_to_back();
    test_stall();
    test_random_pipe2();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
